// File: rtl/read_write_enable_width_downsizer.sv
// read_write_enable_width_downsizer
//
// Reader on the read port of an upstream first-word-fall-through buffer that
// holds wide words of WIDTH*RATIO bits. Each wide word is split into RATIO
// narrow words of WIDTH bits, least significant slice first. The narrow words
// are presented on a downstream read_enable/empty port at one word per cycle.
//
// Ports
//   clock                 system clock, rising edge
//   resetn                asynchronous active-low reset
//   upstream_empty        upstream has no word; upstream_read_data invalid
//   upstream_read_enable  pops the upstream head word on the rising edge
//   upstream_read_data    upstream head wide word (first-word fall-through)
//   read_enable           downstream pops the current narrow word
//   read_data             current narrow word, valid when empty is low
//   empty                 no narrow word available
module read_write_enable_width_downsizer #(
  parameter  int WIDTH       = 8,
  parameter  int RATIO       = 4,
  localparam int INDEX_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   upstream_empty,
  output logic                   upstream_read_enable,
  input  logic [WIDTH*RATIO-1:0] upstream_read_data,
  input  logic                   read_enable,
  output logic [WIDTH-1:0]       read_data,
  output logic                   empty
);

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(RATIO - 1);

  // Held wide word, viewed as RATIO slices so the index selects a slice.
  logic [RATIO-1:0][WIDTH-1:0] buffer_data;
  logic                        buffer_valid;
  logic [INDEX_WIDTH-1:0]      index;

  logic pop;
  logic last;

  assign last  = buffer_valid && (index == LAST_INDEX);
  assign pop   = read_enable && buffer_valid;
  assign empty = !buffer_valid;

  // Refill when the buffer is empty, or when the final slice leaves this
  // cycle so the next word lands on the same edge with no bubble. Gated by
  // resetn so upstream is never popped while reset is held.
  assign upstream_read_enable = resetn && !upstream_empty
                                && (!buffer_valid || (pop && last));

  // A single-slice word needs no index mux; when empty the stale slice shows.
  generate
    if (RATIO == 1) begin : g_single
      assign read_data = buffer_data[0];
    end else begin : g_multi
      assign read_data = buffer_data[index];
    end
  endgenerate

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      buffer_data  <= '0;
      buffer_valid <= 1'b0;
      index        <= '0;
    end else if (upstream_read_enable) begin
      buffer_data  <= upstream_read_data;
      buffer_valid <= 1'b1;
      index        <= '0;
    end else if (pop && last) begin
      buffer_valid <= 1'b0;
      index        <= '0;
    end else if (pop) begin
      // Not last, so index+1 stays within RATIO-1.
      index <= index + INDEX_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_read_write_enable_width_downsizer.sv
// Bench for read_write_enable_width_downsizer: a RATIO=4 instance driven by
// directed tests plus random traffic, and a RATIO=1 instance driven by random
// traffic. Each instance has an upstream queue, a remaining-slice model and an
// in-order scoreboard of narrow words, checked on every falling edge.
module tb_read_write_enable_width_downsizer;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int WW = W * R;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- instance A: RATIO=4 ----------------
  logic          a_ue, a_ure, a_re, a_empty, a_stall, a_pend;
  logic [WW-1:0] a_ud;
  logic [W-1:0]  a_rd;
  logic [WW-1:0] aq[$];
  logic [W-1:0]  aexp[$], a_log[$];
  int            a_popc[$], a_urec[$];
  int            a_cycle = 0;
  logic [WW-1:0] am_word;
  int            am_avail;

  read_write_enable_width_downsizer #(.WIDTH(W), .RATIO(R)) dut_a (
    .clock(clock), .resetn(resetn),
    .upstream_empty(a_ue), .upstream_read_enable(a_ure), .upstream_read_data(a_ud),
    .read_enable(a_re), .read_data(a_rd), .empty(a_empty)
  );

  task automatic a_refresh();
    a_ue = (aq.size() == 0) || a_stall;
    a_ud = (aq.size() != 0) ? aq[0] : '0;
  endtask

  // One cycle: retire the upstream pop of the last edge, then set inputs.
  task automatic cyc(input logic re, input logic st);
    @(posedge clock); #1;
    if (a_pend) void'(aq.pop_front());
    a_pend  = 1'b0;
    a_re    = re;
    a_stall = st;
    a_refresh();
    #1;
  endtask

  always @(negedge clock) begin
    logic         eu;
    logic [W-1:0] erd;
    a_cycle++;
    if (!resetn) begin
      am_word = '0; am_avail = 0; aexp.delete();
    end
    eu  = resetn && !a_ue && (am_avail == 0 || (a_re && am_avail == 1));
    erd = am_word[((am_avail == 0) ? 0 : (R - am_avail)) * W +: W];
    chk("a_empty", 32'(a_empty), 32'(am_avail == 0));
    chk("a_read_data", 32'(a_rd), 32'(erd));
    chk("a_upstream_read_enable", 32'(a_ure), 32'(eu));
    if (a_ure) a_urec.push_back(a_cycle);
    if (a_re && !a_empty) begin
      if (aexp.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_stream: popped %0h, expected no word", a_rd);
      end else chk("a_stream", 32'(a_rd), 32'(aexp.pop_front()));
      a_log.push_back(a_rd);
      a_popc.push_back(a_cycle);
    end
    if (eu) begin
      am_word = a_ud; am_avail = R; a_pend = 1'b1;
      for (int k = 0; k < R; k++) aexp.push_back(a_ud[k*W +: W]);
    end else if (a_re && am_avail > 0) am_avail--;
  end

  // ---------------- instance B: RATIO=1 ----------------
  logic         b_ue, b_ure, b_re, b_empty, b_stall, b_pend;
  logic [W-1:0] b_ud, b_rd, bm_word;
  logic         bm_full;
  logic [W-1:0] bq[$], bexp[$], b_log[$];
  logic         b_go = 1'b0, b_done = 1'b0;

  read_write_enable_width_downsizer #(.WIDTH(W), .RATIO(1)) dut_b (
    .clock(clock), .resetn(resetn),
    .upstream_empty(b_ue), .upstream_read_enable(b_ure), .upstream_read_data(b_ud),
    .read_enable(b_re), .read_data(b_rd), .empty(b_empty)
  );

  task automatic b_refresh();
    b_ue = (bq.size() == 0) || b_stall;
    b_ud = (bq.size() != 0) ? bq[0] : '0;
  endtask

  always @(negedge clock) begin
    logic eu;
    if (!resetn) begin
      bm_word = '0; bm_full = 1'b0; bexp.delete();
    end
    eu = resetn && !b_ue && (!bm_full || b_re);
    chk("b_empty", 32'(b_empty), 32'(!bm_full));
    chk("b_read_data", 32'(b_rd), 32'(bm_word));
    chk("b_upstream_read_enable", 32'(b_ure), 32'(eu));
    if (b_re && !b_empty) begin
      if (bexp.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_stream: popped %0h, expected no word", b_rd);
      end else chk("b_stream", 32'(b_rd), 32'(bexp.pop_front()));
      b_log.push_back(b_rd);
    end
    if (eu) begin
      bm_word = b_ud; bm_full = 1'b1; b_pend = 1'b1; bexp.push_back(b_ud);
    end else if (b_re) bm_full = 1'b0;
  end

  initial begin
    b_re = 1'b0; b_stall = 1'b0; b_pend = 1'b0;
    b_refresh();
    wait (b_go);
    for (int i = 0; i < 200; i++) bq.push_back(W'($urandom));
    for (int c = 0; c < 4000 && !(bq.size() == 0 && b_empty === 1'b1); c++) begin
      @(posedge clock); #1;
      if (b_pend) void'(bq.pop_front());
      b_pend  = 1'b0;
      b_re    = 1'($urandom % 2);
      b_stall = 1'($urandom % 2);
      b_refresh();
    end
    b_done = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    a_re = 1'b0; a_stall = 1'b0; a_pend = 1'b0;
    aq.push_back(32'h44332211);
    a_refresh();
    #1 resetn = 1'b0;

    // Reset with upstream non-empty: no pop while held, pop on release.
    cyc(0, 0); cyc(0, 0);
    chk("rst_upstream_read_enable", 32'(a_ure), 32'h0);
    chk("rst_empty", 32'(a_empty), 32'h1);
    chk("rst_read_data", 32'(a_rd), 32'h0);
    resetn = 1'b1; #1;
    chk("rel_upstream_read_enable", 32'(a_ure), 32'h1);
    cyc(0, 0);
    chk("rel_empty", 32'(a_empty), 32'h0);
    chk("rel_read_data", 32'(a_rd), 32'h11);
    for (int i = 0; i < 6; i++) cyc(1, 0);

    // Single word then upstream empty.
    a_log.delete(); a_urec.delete();
    aq.push_back(32'hDDCCBBAA);
    for (int i = 0; i < 7; i++) cyc(1, 0);
    chk("one_count", 32'(a_log.size()), 32'd4);
    chk("one_d0", 32'(a_log[0]), 32'hAA);
    chk("one_d1", 32'(a_log[1]), 32'hBB);
    chk("one_d2", 32'(a_log[2]), 32'hCC);
    chk("one_d3", 32'(a_log[3]), 32'hDD);
    chk("one_pulses", 32'(a_urec.size()), 32'd1);
    chk("one_empty", 32'(a_empty), 32'h1);

    // Three queued words, back-to-back.
    a_log.delete(); a_urec.delete(); a_popc.delete();
    aq.push_back(32'h03020100); aq.push_back(32'h07060504); aq.push_back(32'h0B0A0908);
    for (int i = 0; i < 15; i++) cyc(1, 0);
    chk("three_count", 32'(a_log.size()), 32'd12);
    for (int i = 0; i < 12; i++) chk("three_data", 32'(a_log[i]), 32'(i));
    chk("three_no_bubble", 32'(a_popc[11] - a_popc[0]), 32'd11);
    chk("three_pops", 32'(a_urec.size()), 32'd3);
    chk("three_pop1_at4", 32'(a_urec[1] - a_urec[0]), 32'd4);
    chk("three_pop2_at8", 32'(a_urec[2] - a_urec[0]), 32'd8);

    // Toggled read_enable: order kept, refill only on the 4th pop.
    a_log.delete(); a_urec.delete(); a_popc.delete();
    aq.push_back(32'h44332211); aq.push_back(32'h88776655);
    for (int i = 0; i < 20; i++) cyc(i % 2 == 0, 0);
    chk("tog_count", 32'(a_log.size()), 32'd8);
    chk("tog_d0", 32'(a_log[0]), 32'h11);
    chk("tog_d1", 32'(a_log[1]), 32'h22);
    chk("tog_d2", 32'(a_log[2]), 32'h33);
    chk("tog_d3", 32'(a_log[3]), 32'h44);
    chk("tog_d4", 32'(a_log[4]), 32'h55);
    chk("tog_refill_on_4th", 32'(a_urec[1]), 32'(a_popc[3]));

    // read_enable while empty is ignored; next word starts at slice 0.
    a_log.delete(); a_urec.delete();
    for (int i = 0; i < 5; i++) cyc(1, 0);
    chk("idle_pops", 32'(a_log.size()), 32'd0);
    chk("idle_upstream", 32'(a_urec.size()), 32'd0);
    chk("idle_empty", 32'(a_empty), 32'h1);
    aq.push_back(32'hA3A2A1A0);
    for (int i = 0; i < 7; i++) cyc(1, 0);
    chk("idle_first", 32'(a_log[0]), 32'hA0);
    chk("idle_last", 32'(a_log[3]), 32'hA3);

    // Reset mid-word: remaining slices dropped, no pop during reset.
    a_log.delete(); a_urec.delete();
    aq.push_back(32'h5E5D5C5B);
    cyc(1, 0); cyc(1, 0); cyc(1, 0); cyc(0, 0);
    resetn = 1'b0;
    aq.push_back(32'h77665544);
    cyc(0, 0); cyc(0, 0);
    chk("rstmid_upstream", 32'(a_urec.size()), 32'd1);
    chk("rstmid_empty", 32'(a_empty), 32'h1);
    a_log.delete();
    resetn = 1'b1;
    for (int i = 0; i < 7; i++) cyc(1, 0);
    chk("rstmid_count", 32'(a_log.size()), 32'd4);
    chk("rstmid_first", 32'(a_log[0]), 32'h44);

    // Random traffic on both instances.
    b_go = 1'b1;
    a_log.delete();
    for (int i = 0; i < 200; i++) aq.push_back(WW'($urandom));
    for (int c = 0; c < 6000 && !(aq.size() == 0 && a_empty === 1'b1); c++)
      cyc(1'($urandom % 2), 1'($urandom % 2));
    chk("a_rand_words", 32'(a_log.size()), 32'd800);
    for (int c = 0; c < 5000 && !b_done; c++) @(posedge clock);
    #2;
    chk("b_rand_done", 32'(b_done), 32'h1);
    chk("b_rand_words", 32'(b_log.size()), 32'd200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_write_enable_width_downsizer.md
Name: read_write_enable_width_downsizer

Overview:
- Consumer-side block for the read_write_enable protocol, which uses write_enable/full and read_enable/empty handshakes with first-word fall-through.
- Acts as the reader attached to the read port of an upstream buffer (skid buffer or FIFO) that holds wide words of WIDTH*RATIO bits.
- Splits each wide word into RATIO narrow words of WIDTH bits, least significant slice first.
- Re-exposes the narrow words downstream on its own read_enable/empty read port at full throughput.

Parameters:
- WIDTH, 8: downstream (narrow) data width in bits, >=1.
- RATIO, 4: narrow words per wide word, >=1.
- INDEX_WIDTH, max($clog2(RATIO),1): width of the slice index counter; derived, not overridden.

Ports:
- clock  input  1  system clock, rising-edge active.
- resetn  input  1  asynchronous active-low reset.
- upstream_empty  input  1  upstream buffer has no data; upstream_read_data is invalid when high.
- upstream_read_enable  output  1  pops one wide word from upstream on the rising edge.
- upstream_read_data  input  WIDTH*RATIO  head wide word of upstream, first-word fall-through.
- read_enable  input  1  downstream pops one narrow word on the rising edge.
- read_data  output  WIDTH  current narrow word, valid when empty is low.
- empty  output  1  no narrow word available.

Behaviour:
- Interface: one clock, clock; reset is asynchronous and active-low on resetn.

State registers:
- buffer_data [WIDTH*RATIO-1:0]
- buffer_valid (1 bit)
- index [INDEX_WIDTH-1:0]
- Reset values: buffer_data=0, buffer_valid=0, index=0. Reset takes effect immediately on resetn falling, independent of clock.

Outputs:
- empty = !buffer_valid. Reset value 1.
- read_data = buffer_data[index*WIDTH +: WIDTH], driven combinationally. Reset value 0. Undefined content is not allowed; when empty, read_data shows the stale slice.
- last = buffer_valid && (index == RATIO-1); internal signal only.
- pop = read_enable && buffer_valid. read_enable while empty is ignored: no state change, no error.
- upstream_read_enable = resetn && !upstream_empty && (!buffer_valid || (pop && last)). It is never asserted while upstream_empty=1 or while resetn=0.

Clock edge actions:
- On upstream_read_enable: buffer_data <= upstream_read_data, buffer_valid <= 1, index <= 0.
- Else on pop && last: buffer_valid <= 0, index <= 0.
- Else on pop: index <= index+1. No modulo is needed because index+1 <= RATIO-1.

Latency and throughput:
- A wide word popped from upstream is visible downstream in the next cycle, so empty falls one cycle after upstream_read_enable.
- Pop-on-last with upstream non-empty reloads in the same edge. This gives one narrow word per cycle indefinitely, with no bubble between wide words.
- The upstream pop rate is therefore at most 1 per RATIO cycles when the buffer is full.

Boundary conditions:
- RATIO=1: degenerates to a one-entry registered stage. index stays 0, last=buffer_valid, and the block sustains full throughput.
- Upstream empty at the last pop: the buffer goes empty and the next word loads as soon as upstream_empty falls.
- Reset mid-word: remaining slices are discarded. Upstream is not popped during reset.

Test Plan:
- Reset with upstream_empty=0 and upstream_read_data=32'h44332211 -> upstream_read_enable=0 and empty=1 during reset. In the first cycle after release, upstream_read_enable=1, then empty=0 with read_data=8'h11.
- One word 32'hDDCCBBAA, upstream then empty, read_enable held high -> read_data is AA,BB,CC,DD on 4 consecutive cycles. Then empty=1. upstream_read_enable pulses exactly once.
- Three words 32'h03020100, 32'h07060504, 32'h0B0A0908 queued upstream, read_enable=1 continuously -> 12 consecutive narrow words 00..0B with no empty cycle. upstream_read_enable is high on cycles 0, 4 and 8 only.
- Word 32'h44332211 loaded, read_enable toggled 1,0,1,0,... -> data order 11,22,33,44 is preserved. index holds on idle cycles. The next upstream pop occurs only on the 4th pop.
- read_enable=1 while empty=1 for 5 cycles -> no index change and no upstream pop. A word arriving afterwards begins at slice 0.
- Random upstream_empty/read_enable at 50% each, 200 wide words, RATIO=4 and RATIO=1 builds -> scoreboard matches every narrow word in order. upstream_read_enable is never high while upstream_empty is high.
